// File: rtl/ov7670_cfg_pkg.sv
// OV7670 SCCB config: FSM encoding, table markers, ms->cycles helper.
// Shared by ov7670_reg_rom and ov7670_sccb_cfg_ctrl.
package ov7670_cfg_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_LOAD,
    ST_START,
    ST_BYTE,
    ST_STOP,
    ST_GAP,
    ST_DELAY,
    ST_DONE
  } state_t;

  localparam logic [15:0] CFG_DELAY = 16'hFFF0;
  localparam logic [15:0] CFG_END   = 16'hFFFF;

  function automatic int unsigned ms_to_cycles(
    input int unsigned clk_hz,
    input int unsigned ms
  );
    longint unsigned c;
    c = 64'(clk_hz) * 64'(ms) / 64'd1000;
    return (c == 64'd0) ? 32'd1 : 32'(c);
  endfunction

endpackage

// File: rtl/ov7670_sccb_cfg_ctrl_if.sv
// SCCB pin bundle between the config controller and the pad logic.
// master drives SIOC/SIOD; slave is the pad/observer side.
interface ov7670_sccb_cfg_ctrl_if;

  logic sioc;
  logic siod_o;
  logic siod_oe;

  modport master (
    output sioc,
    output siod_o,
    output siod_oe
  );

  modport slave (
    input sioc,
    input siod_o,
    input siod_oe
  );

endinterface

// File: rtl/ov7670_reg_rom.sv
// OV7670 power-up register table, one-cycle synchronous read.
// Entries are {reg,val}; FFF0 = delay marker, FFFF = end marker.
module ov7670_reg_rom
  import ov7670_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  addr,
  output logic [15:0] data
);

  logic [15:0] entry;

  always_comb begin
    entry = CFG_END;
    unique case (addr)
      8'd0:    entry = 16'h1280;
      8'd1:    entry = CFG_DELAY;
      8'd2:    entry = 16'h1204;
      8'd3:    entry = 16'h8C02;
      8'd4:    entry = 16'h40D0;
      8'd5:    entry = 16'h1100;
      default: entry = CFG_END;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data <= CFG_END;
    else        data <= entry;
  end

endmodule

// File: rtl/ov7670_sccb_cfg_ctrl.sv
// OV7670 power-up sequencer: walks the register table with SCCB 3-phase writes.
// Optional feature macro CFG_RETRIGGER_EN: cfg_start in DONE replays the table.
module ov7670_sccb_cfg_ctrl
  import ov7670_cfg_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 25_000_000,
  parameter int unsigned SCCB_HZ  = 100_000,
  parameter logic [7:0]  DEV_ADDR = 8'h42,
  parameter int unsigned PWRUP_MS = 1,
  parameter int unsigned DELAY_MS = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  ov7670_sccb_cfg_ctrl_if.master        sccb,
  output logic                          busy,
  output logic                          done,
  output logic [7:0]                    cfg_idx
);

  localparam int unsigned QTR_RAW = CLK_HZ / (4 * SCCB_HZ);
  localparam int unsigned QTR     = (QTR_RAW == 0) ? 1 : QTR_RAW;
  localparam int unsigned PWR_CYC = ms_to_cycles(CLK_HZ, PWRUP_MS);
  localparam int unsigned DLY_CYC = ms_to_cycles(CLK_HZ, DELAY_MS);
  localparam int unsigned MAX_A   = (PWR_CYC > DLY_CYC) ? PWR_CYC : DLY_CYC;
  localparam int unsigned MAX_C   = (MAX_A > QTR) ? MAX_A : QTR;
  localparam int          CW      = $clog2(MAX_C + 1);

  typedef logic [CW-1:0] cnt_t;

  state_t      state;
  state_t      state_n;
  cnt_t        cnt;
  cnt_t        lim;
  logic        tick;
  logic [1:0]  q;
  logic [3:0]  bitc;
  logic [1:0]  bytec;
  logic [7:0]  sh;
  logic [15:0] ent;
  logic [15:0] rom_q;
  logic        ld_vld;
  logic        run;
  logic        last_q;
  logic        last_bit;
  logic        last_byte;
  logic        retrig;
  logic        sioc_c;
  logic        siod_c;
  logic        oe_c;

`ifdef CFG_RETRIGGER_EN
  assign retrig = cfg_start;
`else
  logic unused_start;
  assign retrig       = 1'b0;
  assign unused_start = cfg_start;
`endif

  ov7670_reg_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (cfg_idx),
    .data  (rom_q)
  );

  always_comb begin
    lim = cnt_t'(QTR - 1);
    unique case (state)
      ST_PWRUP: lim = cnt_t'(PWR_CYC - 1);
      ST_DELAY: lim = cnt_t'(DLY_CYC - 1);
      default:  lim = cnt_t'(QTR - 1);
    endcase
  end

  assign tick      = (cnt == lim);
  assign last_q    = (q == 2'd3);
  assign last_bit  = (bitc == 4'd8);
  assign last_byte = (bytec == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_PWRUP;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_PWRUP: if (tick) state_n = ST_LOAD;
      ST_LOAD: begin
        if (ld_vld) begin
          unique case (1'b1)
            (rom_q == CFG_END):   state_n = ST_DONE;
            (rom_q == CFG_DELAY): state_n = ST_DELAY;
            default:              state_n = ST_START;
          endcase
        end
      end
      ST_START: if (tick) state_n = ST_BYTE;
      ST_BYTE: begin
        if (tick && last_q && last_bit && last_byte)
          state_n = ST_STOP;
      end
      ST_STOP:  if (tick && q == 2'd2) state_n = ST_GAP;
      ST_GAP:   if (tick && last_q) state_n = ST_LOAD;
      ST_DELAY: if (tick) state_n = ST_LOAD;
      ST_DONE:  if (retrig) state_n = ST_LOAD;
      default:  state_n = ST_PWRUP;
    endcase
  end

  // ROM address is cfg_idx, so LOAD waits one cycle for the read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      ld_vld  <= 1'b0;
      cnt     <= '0;
      q       <= '0;
      bitc    <= '0;
      bytec   <= '0;
      sh      <= '0;
      ent     <= '0;
      cfg_idx <= '0;
    end else begin
      run    <= 1'b1;
      ld_vld <= (state == ST_LOAD) && !ld_vld;

      if (state == ST_LOAD || state == ST_DONE)
        cnt <= '0;
      else
        cnt <= tick ? '0 : cnt + 1'b1;

      if (state_n != state) q <= '0;
      else if (tick)        q <= q + 1'b1;

      if (state == ST_LOAD && ld_vld) begin
        ent   <= rom_q;
        sh    <= DEV_ADDR;
        bitc  <= '0;
        bytec <= '0;
      end else if (state == ST_BYTE && tick && last_q) begin
        if (last_bit) begin
          bitc  <= '0;
          bytec <= bytec + 1'b1;
          sh    <= (bytec == 2'd0) ? ent[15:8] : ent[7:0];
        end else begin
          bitc <= bitc + 1'b1;
          sh   <= {sh[6:0], 1'b0};
        end
      end

      if ((state == ST_GAP && tick && last_q) ||
          (state == ST_DELAY && tick))
        cfg_idx <= cfg_idx + 1'b1;
      else if (state == ST_DONE && retrig)
        cfg_idx <= '0;
    end
  end

  // Bus pins follow state directly so async reset releases them at once
  always_comb begin
    sioc_c = 1'b1;
    siod_c = 1'b1;
    oe_c   = 1'b0;
    unique case (state)
      ST_START: begin
        siod_c = 1'b0;
        oe_c   = 1'b1;
      end
      ST_BYTE: begin
        sioc_c = q[1];
        if (!last_bit) begin
          siod_c = sh[7];
          oe_c   = 1'b1;
        end
      end
      ST_STOP: begin
        sioc_c = (q != 2'd0);
        siod_c = (q == 2'd2);
        oe_c   = 1'b1;
      end
      default: begin
        sioc_c = 1'b1;
        siod_c = 1'b1;
        oe_c   = 1'b0;
      end
    endcase
  end

  assign sccb.sioc    = sioc_c;
  assign sccb.siod_o  = siod_c;
  assign sccb.siod_oe = oe_c;
  assign busy         = run && (state != ST_DONE);
  assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_ov7670_sccb_cfg_ctrl.sv
// Directed bench for ov7670_sccb_cfg_ctrl: decodes SCCB writes from the pins.
// Sim params: CLK_HZ=4M, SCCB_HZ=100k (QTR=10), PWRUP_MS=DELAY_MS=1 (4000 cycles).
module tb_ov7670_sccb_cfg_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cfg_start;
  logic       busy;
  logic       done;
  logic [7:0] cfg_idx;

  ov7670_sccb_cfg_ctrl_if sccb ();

  ov7670_sccb_cfg_ctrl #(
    .CLK_HZ   (4_000_000),
    .SCCB_HZ  (100_000),
    .DEV_ADDR (8'h42),
    .PWRUP_MS (1),
    .DELAY_MS (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .sccb      (sccb),
    .busy      (busy),
    .done      (done),
    .cfg_idx   (cfg_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic line;
  assign line = sccb.siod_oe ? sccb.siod_o : 1'b1;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_rise   = 0;
  int   n_stop   = 0;
  logic p_sioc   = 1'b1;
  logic p_line   = 1'b1;
  logic ev_start = 1'b0;
  logic ev_stop  = 1'b0;
  logic ev_rise  = 1'b0;

  logic [23:0] exp_w [5];
  logic [7:0]  exp_i [5];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    ev_start = p_sioc && sccb.sioc && p_line && !line;
    ev_stop  = p_sioc && sccb.sioc && !p_line && line;
    ev_rise  = !p_sioc && sccb.sioc;
    if (ev_rise) n_rise++;
    if (ev_stop) n_stop++;
    p_sioc = sccb.sioc;
    p_line = line;
  endtask

  task automatic get_write(output logic [23:0] w, output logic [7:0] idx,
                           output int t0, output int t1, output int r0);
    logic [26:0] bits;
    logic        ack_drv;
    logic        bit_to;
    int          n;
    bits    = '0;
    ack_drv = 1'b0;
    bit_to  = 1'b0;
    w       = '0;
    idx     = '0;
    t0      = -1;
    t1      = -1;
    r0      = n_rise;
    n = 0;
    tick();
    while (!ev_start && n < 6000) begin
      tick();
      n++;
    end
    chk("start_seen", 32'(ev_start), 32'd1);
    if (!ev_start) return;
    t0  = cyc;
    idx = cfg_idx;
    r0  = n_rise;
    for (int k = 0; k < 27; k++) begin
      n = 0;
      tick();
      while (!ev_rise && n < 100) begin
        tick();
        n++;
      end
      bit_to |= !ev_rise;
      bits[26-k] = line;
      if (k % 9 == 8) ack_drv |= sccb.siod_oe;
    end
    chk("bit_clocks", 32'(bit_to), 32'd0);
    chk("ack_released", 32'(ack_drv), 32'd0);
    n = 0;
    tick();
    while (!ev_stop && n < 100) begin
      tick();
      n++;
    end
    chk("stop_seen", 32'(ev_stop), 32'd1);
    t1 = cyc;
    chk("stop_bus", 32'({sccb.sioc, sccb.siod_o}), 32'd3);
    w = {bits[26:19], bits[17:10], bits[8:1]};
  endtask

  initial begin
    logic [23:0] w;
    logic [7:0]  idx;
    int          t0;
    int          t1;
    int          r0;
    int          prev_stop;
    int          prev_rise;
    int          base_stop;
    int          base_rise;
    int          n;

    exp_w = '{24'h421280, 24'h421204, 24'h428C02, 24'h4240D0, 24'h421100};
    exp_i = '{8'd0, 8'd2, 8'd3, 8'd4, 8'd5};
    prev_stop = 0;
    prev_rise = 0;

    rst_n     = 1'b0;
    cfg_start = 1'b0;
    repeat (4) tick();
    chk("rst_sioc", 32'(sccb.sioc), 32'd1);
    chk("rst_siod", 32'({sccb.siod_oe, sccb.siod_o}), 32'b01);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);
    chk("rst_idx", 32'(cfg_idx), 32'd0);

    rst_n  = 1'b1;
    cyc    = 0;
    n_rise = 0;
    n_stop = 0;
    tick();
    chk("pwrup_state", 32'({busy, done, sccb.sioc, sccb.siod_oe}), 32'b1010);

    for (int i = 0; i < 5; i++) begin
      get_write(w, idx, t0, t1, r0);
      chk($sformatf("w%0d_bytes", i), 32'(w), 32'(exp_w[i]));
      chk($sformatf("w%0d_idx", i), 32'(idx), 32'(exp_i[i]));
      if (i == 0) begin
        chk("first_start_cycle", 32'(t0), 32'd4002);
        chk("xfer_length", 32'(t1 - t0), 32'd1110);
      end
      if (i == 1) begin
        chk("delay_gap", 32'(t0 - prev_stop), 32'd4054);
        chk("delay_quiet", 32'(r0 - prev_rise), 32'd0);
      end
      if (i == 2) chk("entry_gap", 32'(t0 - prev_stop), 32'd52);
      prev_stop = t1;
      prev_rise = n_rise;
    end

    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("done_cycle", 32'(cyc - prev_stop), 32'd52);
    chk("done_outputs", 32'({done, busy, sccb.sioc, sccb.siod_oe}), 32'b1010);
    chk("done_idx", 32'(cfg_idx), 32'd6);
    chk("stop_count", 32'(n_stop), 32'd5);

    repeat (20) tick();
    base_stop = n_stop;
    base_rise = n_rise;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
`ifdef CFG_RETRIGGER_EN
    chk("retrig_flags", 32'({done, busy}), 32'b01);
    chk("retrig_idx", 32'(cfg_idx), 32'd0);
    for (int i = 0; i < 5; i++) begin
      get_write(w, idx, t0, t1, r0);
      chk($sformatf("rw%0d_bytes", i), 32'(w), 32'(exp_w[i]));
      chk($sformatf("rw%0d_idx", i), 32'(idx), 32'(exp_i[i]));
      if (i == 0) begin
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("busy_start_ignored", 32'(cfg_idx), 32'd0);
      end
    end
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("redone_flags", 32'({done, busy}), 32'b10);
    chk("replay_stops", 32'(n_stop - base_stop), 32'd5);
`else
    repeat (200) tick();
    chk("no_retrig_flags", 32'({done, busy}), 32'b10);
    chk("no_retrig_quiet", 32'(n_rise - base_rise), 32'd0);
    chk("no_retrig_stops", 32'(n_stop - base_stop), 32'd0);
    chk("no_retrig_idx", 32'(cfg_idx), 32'd6);
`endif

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    cyc   = 0;
    get_write(w, idx, t0, t1, r0);
    chk("run2_w0_bytes", 32'(w), 32'h421280);
    n = 0;
    tick();
    while (!ev_start && n < 6000) begin
      tick();
      n++;
    end
    chk("e2_start_seen", 32'(ev_start), 32'd1);
    repeat (150) tick();
    n = 0;
    while (sccb.sioc && n < 40) begin
      tick();
      n++;
    end
    chk("pre_rst_bus", 32'({sccb.sioc, sccb.siod_oe}), 32'b01);
    chk("pre_rst_idx", 32'(cfg_idx), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_bus",
        32'({sccb.sioc, sccb.siod_oe, sccb.siod_o}), 32'b101);
    chk("async_rst_flags", 32'({busy, done, cfg_idx}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    cyc   = 0;
    get_write(w, idx, t0, t1, r0);
    chk("restart_start_cycle", 32'(t0), 32'd4002);
    chk("restart_bytes", 32'(w), 32'h421280);
    chk("restart_idx", 32'(idx), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
